lzd_norm: RTL and testbench



---
 rtl/lzd_norm.sv | 124 ++++++++++++
 tb/tb_lzd_norm.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lzd_norm.sv
// lzd_norm: three-stage pipelined left normalizer steered by a registered leading-zero count.
// Emits a mantissa with bit 47 set, exponent EXP_BASE - count, and a sticky count/operand checker.
module lzd_norm #(
   parameter int EXP_BASE = 0,
   parameter int EXP_W    = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             scan_in0,
   input  logic             scan_en,
   input  logic             test_mode,
   output logic             scan_out0,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [47:0]      din,
   input  logic [5:0]       numz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [47:0]      mant,
   output logic [EXP_W-1:0] exp,
   output logic             zero,
   output logic             err
);
   localparam logic [5:0] CNT_ZERO = 6'd48;

   logic             adv;
   logic             unused_scan;

   logic             s1_valid_q, s1_zero_q, s1_nz_q, s1_bad_q;
   logic [5:0]       s1_cnt_q;
   logic [47:0]      s1_data_q;
   logic             s1_zero_d;
   logic [5:0]       s1_cnt_d;
   logic [47:0]      s1_data_d;

   logic             s2_valid_q, s2_zero_q, s2_nz_q, s2_bad_q;
   logic [5:0]       s2_cnt_q;
   logic [47:0]      s2_data_q;
   logic [47:0]      s2_shift16;
   logic [47:0]      s2_data_d;

   logic             out_valid_q, zero_q, err_q, err_pend_q;
   logic [47:0]      mant_q;
   logic [EXP_W-1:0] exp_q;
   logic [47:0]      s3_shift;
   logic [47:0]      mant_d;
   logic [EXP_W-1:0] exp_d;
   logic             mism_d;

   // The whole pipeline advances or stalls as one, so in_ready is just the output's freedom to move.
   assign adv         = ~out_valid_q | out_ready;
   assign in_ready    = adv;
   assign scan_out0   = 1'b0;
   assign unused_scan = scan_in0 ^ scan_en ^ test_mode;

   always_comb begin
      s1_zero_d = (numz >= CNT_ZERO);
      s1_cnt_d  = s1_zero_d ? CNT_ZERO : numz;
      s1_data_d = s1_zero_d ? 48'h0 : (numz[5] ? {din[15:0], 32'h0} : din);
   end

   always_comb begin
      s2_shift16 = s1_cnt_q[4] ? {s1_data_q[31:0], 16'h0} : s1_data_q;
      s2_data_d  = s2_shift16 << {s1_cnt_q[3:2], 2'b00};
   end

   // Checker judges the shifted value as computed; a bad count is reported, never corrected.
   always_comb begin
      s3_shift = s2_data_q << s2_cnt_q[1:0];
      mant_d   = s2_zero_q ? 48'h0 : s3_shift;
      exp_d    = s2_zero_q ? '0 : (EXP_W'(EXP_BASE) - EXP_W'(s2_cnt_q));
      mism_d   = s2_valid_q & ((~s2_zero_q & ~s3_shift[47]) | (s2_zero_q & s2_nz_q) | s2_bad_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q  <= 1'b0;
         s1_zero_q   <= 1'b0;
         s1_nz_q     <= 1'b0;
         s1_bad_q    <= 1'b0;
         s1_cnt_q    <= '0;
         s1_data_q   <= '0;
         s2_valid_q  <= 1'b0;
         s2_zero_q   <= 1'b0;
         s2_nz_q     <= 1'b0;
         s2_bad_q    <= 1'b0;
         s2_cnt_q    <= '0;
         s2_data_q   <= '0;
         out_valid_q <= 1'b0;
         mant_q      <= '0;
         exp_q       <= '0;
         zero_q      <= 1'b0;
         err_q       <= 1'b0;
         err_pend_q  <= 1'b0;
      end else begin
         err_q      <= err_q | err_pend_q;
         err_pend_q <= adv & mism_d;
         if (adv) begin
            s1_valid_q  <= in_valid;
            s1_zero_q   <= s1_zero_d;
            s1_nz_q     <= |din;
            s1_bad_q    <= (numz > CNT_ZERO);
            s1_cnt_q    <= s1_cnt_d;
            s1_data_q   <= s1_data_d;
            s2_valid_q  <= s1_valid_q;
            s2_zero_q   <= s1_zero_q;
            s2_nz_q     <= s1_nz_q;
            s2_bad_q    <= s1_bad_q;
            s2_cnt_q    <= s1_cnt_q;
            s2_data_q   <= s2_data_d;
            out_valid_q <= s2_valid_q;
            mant_q      <= mant_d;
            exp_q       <= exp_d;
            zero_q      <= s2_zero_q;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign mant      = mant_q;
   assign exp       = exp_q;
   assign zero      = zero_q;
   assign err       = err_q;
endmodule

// File: tb/tb_lzd_norm.sv
// Testbench for lzd_norm: scenario tasks with randomized traffic checked against an arithmetic model.
module tb_lzd_norm;
   localparam int TB_EXP_BASE = 0;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scan_in0 = 1'b0, scan_en = 1'b0, test_mode = 1'b0;
   logic        scan_out0;
   logic        in_valid = 1'b0, in_ready;
   logic [47:0] din = '0;
   logic [5:0]  numz = '0;
   logic        out_valid, out_ready = 1'b0;
   logic [47:0] mant;
   logic [7:0]  exp;
   logic        zero, err;

   int          tests = 0;
   int          fails = 0;
   logic [47:0] qd[$];
   int          qn[$];
   logic        acc, ret, ret_zero;
   logic [47:0] ret_mant;
   logic [7:0]  ret_exp;

   lzd_norm #(.EXP_BASE(TB_EXP_BASE), .EXP_W(8)) dut (
      .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_en(scan_en), .test_mode(test_mode),
      .scan_out0(scan_out0), .in_valid(in_valid), .in_ready(in_ready), .din(din), .numz(numz),
      .out_valid(out_valid), .out_ready(out_ready), .mant(mant), .exp(exp), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   // Model: normalizing is a plain left shift by the count; exponent is base minus count.
   function automatic logic [47:0] ref_mant(input logic [47:0] d, input int n);
      if (n >= 48) return 48'h0;
      return d << n;
   endfunction
   function automatic logic [7:0] ref_exp(input int n);
      if (n >= 48) return 8'h00;
      return 8'(TB_EXP_BASE - n);
   endfunction

   task automatic rand_item(output logic [47:0] d, output logic [5:0] n);
      logic [47:0] r;
      int k;
      k = $urandom_range(0, 48);
      r[31:0]  = $urandom;
      r[47:32] = 16'($urandom);
      if (k == 48) d = 48'h0;
      else begin
         d = r >> k;
         d[47-k] = 1'b1;
      end
      n = 6'(k);
   endtask

   // One clock: drive inputs, note handshakes just before the edge, resume 1 time unit after it.
   task automatic step(input logic v, input logic [47:0] d, input logic [5:0] n, input logic r);
      in_valid = v; din = d; numz = n; out_ready = r;
      #1;
      acc = in_valid & in_ready;
      ret = out_valid & out_ready;
      ret_mant = mant; ret_exp = exp; ret_zero = zero;
      if (acc) begin
         qd.push_back(din);
         qn.push_back(int'(numz));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; din = '0; numz = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      qd.delete(); qn.delete();
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #7;
      tests++;
      if ({out_valid, mant, exp, zero, err, scan_out0} !== '0) begin
         fails++; $display("FAIL reset_outputs: got v=%b m=%h e=%h z=%b err=%b so=%b expected all 0", out_valid, mant, exp, zero, err, scan_out0);
      end
      @(posedge clk); #1 reset = 1'b0;
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      $display("[TB] reset: done");
   endtask

   task automatic test_basic();
      step(1'b1, 48'h1, 6'd47, 1'b1);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat1: out_valid got %b expected 0", out_valid); end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_lat2: out_valid got %b expected 0", out_valid); end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({out_valid, mant, exp, zero, err} !== {1'b1, 48'h800000000000, 8'hD1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL basic_out: got v=%b m=%h e=%h z=%b err=%b expected v=1 m=800000000000 e=d1 z=0 err=0", out_valid, mant, exp, zero, err);
      end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({ret, out_valid, err} !== 3'b100) begin fails++; $display("FAIL basic_retire: got ret=%b v=%b err=%b expected 1 0 0", ret, out_valid, err); end
      qd.delete(); qn.delete();
      $display("[TB] basic: din=1 numz=47 -> m=%h e=%h", ret_mant, ret_exp);
   endtask

   task automatic test_back_to_back();
      step(1'b1, 48'h800000000000, 6'd0, 1'b1);
      step(1'b1, 48'h00000F000000, 6'd20, 1'b1);
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({out_valid, mant, exp} !== {1'b1, 48'h800000000000, 8'h00}) begin
         fails++; $display("FAIL b2b_first: got v=%b m=%h e=%h expected v=1 m=800000000000 e=00", out_valid, mant, exp);
      end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({ret, out_valid, mant, exp} !== {2'b11, 48'hF00000000000, 8'hEC}) begin
         fails++; $display("FAIL b2b_second: got ret=%b v=%b m=%h e=%h expected ret=1 v=1 m=f00000000000 e=ec", ret, out_valid, mant, exp);
      end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({ret, out_valid} !== 2'b10) begin fails++; $display("FAIL b2b_drain: got ret=%b v=%b expected 1 0", ret, out_valid); end
      qd.delete(); qn.delete();
      $display("[TB] back_to_back: two items on consecutive cycles");
   endtask

   task automatic test_zero();
      logic [5:0] nz [2];
      nz[0] = 6'd48; nz[1] = 6'd55;
      for (int i = 0; i < 2; i++) begin
         step(1'b1, 48'h0, nz[i], 1'b1);
         step(1'b0, 48'h0, 6'd0, 1'b1);
         step(1'b0, 48'h0, 6'd0, 1'b1);
         tests++;
         if ({out_valid, zero, mant, exp, err} !== {2'b11, 48'h0, 8'h00, 1'b0}) begin
            fails++; $display("FAIL zero_out_n%0d: got v=%b z=%b m=%h e=%h err=%b expected 1 1 0 00 0", nz[i], out_valid, zero, mant, exp, err);
         end
         step(1'b0, 48'h0, 6'd0, 1'b1);
         tests++;
         if (err !== (i == 1)) begin fails++; $display("FAIL zero_err_n%0d: got %b expected %b", nz[i], err, (i == 1)); end
         $display("[TB] zero: numz=%0d err=%b", nz[i], err);
      end
      qd.delete(); qn.delete();
   endtask

   task automatic test_backpressure();
      logic [47:0] d [5];
      logic [5:0]  n [5];
      logic [47:0] held_m;
      logic [7:0]  held_e;
      int idx, nret, k;
      do_reset();
      for (int i = 0; i < 5; i++) rand_item(d[i], n[i]);
      idx = 0; nret = 0; held_m = '0; held_e = '0;
      for (int c = 0; c < 6; c++) begin
         step(1'b1, d[idx], n[idx], 1'b0);
         if (acc) idx++;
         if (c == 2) begin held_m = mant; held_e = exp; end
         if (c >= 2) begin
            tests++;
            if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready_c%0d: got %b expected 0", c, in_ready); end
         end
         if (c >= 3) begin
            tests++;
            if ({out_valid, mant, exp} !== {1'b1, held_m, held_e}) begin
               fails++; $display("FAIL bp_stable_c%0d: got v=%b m=%h e=%h expected v=1 m=%h e=%h", c, out_valid, mant, exp, held_m, held_e);
            end
         end
      end
      tests++;
      if (idx !== 3) begin fails++; $display("FAIL bp_accepted: got %0d expected 3", idx); end
      for (int c = 0; c < 15; c++) begin
         k = (idx < 5) ? idx : 0;
         step(idx < 5, d[k], n[k], 1'b1);
         if (acc) idx++;
         if (ret) begin
            tests++;
            if (qd.size() == 0) begin fails++; $display("FAIL bp_extra_output: got m=%h expected none", ret_mant); end
            else begin
               if ({ret_mant, ret_exp, ret_zero} !== {ref_mant(qd[0], qn[0]), ref_exp(qn[0]), qn[0] >= 48}) begin
                  fails++; $display("FAIL bp_item%0d: got m=%h e=%h z=%b expected m=%h e=%h", nret, ret_mant, ret_exp, ret_zero, ref_mant(qd[0], qn[0]), ref_exp(qn[0]));
               end
               void'(qd.pop_front()); void'(qn.pop_front());
            end
            nret++;
         end
      end
      tests++;
      if ({idx, nret, qd.size()} !== {32'd5, 32'd5, 32'd0}) begin
         fails++; $display("FAIL bp_count: got acc=%0d ret=%0d left=%0d expected 5 5 0", idx, nret, qd.size());
      end
      $display("[TB] backpressure: accepted=%0d retired=%0d", idx, nret);
   endtask

   task automatic test_mismatch();
      logic [47:0] d [11];
      logic [5:0]  n [11];
      int idx, nret, k;
      logic seen;
      do_reset();
      d[0] = 48'h000000000100; n[0] = 6'd10;
      for (int i = 1; i < 11; i++) rand_item(d[i], n[i]);
      idx = 0; nret = 0; seen = 1'b0;
      for (int c = 0; c < 20; c++) begin
         k = (idx < 11) ? idx : 0;
         step(idx < 11, d[k], n[k], 1'b1);
         if (acc) idx++;
         if (ret) begin
            tests++;
            if ({ret_mant, ret_exp} !== {ref_mant(qd[0], qn[0]), ref_exp(qn[0])}) begin
               fails++; $display("FAIL mism_item%0d: got m=%h e=%h expected m=%h e=%h", nret, ret_mant, ret_exp, ref_mant(qd[0], qn[0]), ref_exp(qn[0]));
            end
            void'(qd.pop_front()); void'(qn.pop_front());
            nret++;
         end
         if (seen) begin
            tests++;
            if (err !== 1'b1) begin fails++; $display("FAIL mism_sticky_c%0d: err got %b expected 1", c, err); end
         end
         if (out_valid && !seen) begin
            tests++;
            if ({mant, err} !== {48'h000000040000, 1'b0}) begin
               fails++; $display("FAIL mism_first: got m=%h err=%b expected m=000000040000 err=0", mant, err);
            end
            seen = 1'b1;
         end
      end
      tests++;
      if (nret !== 11) begin fails++; $display("FAIL mism_count: got %0d expected 11", nret); end
      $display("[TB] mismatch: retired=%0d err=%b", nret, err);
   endtask

   task automatic test_random();
      logic [47:0] cd;
      logic [5:0]  cn;
      int nret;
      do_reset();
      rand_item(cd, cn);
      nret = 0;
      for (int c = 0; c < 420; c++) begin
         if (c < 400) step($urandom_range(0, 1) == 1, cd, cn, $urandom_range(0, 3) != 0);
         else         step(1'b0, 48'h0, 6'd0, 1'b1);
         if (acc) rand_item(cd, cn);
         if (ret) begin
            tests++;
            if (qd.size() == 0) begin fails++; $display("FAIL rand_extra_output: got m=%h expected none", ret_mant); end
            else begin
               if ({ret_mant, ret_exp, ret_zero} !== {ref_mant(qd[0], qn[0]), ref_exp(qn[0]), qn[0] >= 48}) begin
                  fails++; $display("FAIL rand_item%0d: got m=%h e=%h z=%b expected m=%h e=%h z=%b", nret, ret_mant, ret_exp, ret_zero, ref_mant(qd[0], qn[0]), ref_exp(qn[0]), qn[0] >= 48);
               end
               void'(qd.pop_front()); void'(qn.pop_front());
            end
            nret++;
         end
      end
      tests++;
      if ({qd.size(), err} !== {32'd0, 1'b0}) begin fails++; $display("FAIL rand_drain: got left=%0d err=%b expected 0 0", qd.size(), err); end
      $display("[TB] random: retired=%0d", nret);
   endtask

   task automatic test_reset_midstream();
      logic [47:0] d;
      logic [5:0]  n;
      step(1'b1, 48'h000000000100, 6'd10, 1'b0);
      rand_item(d, n); step(1'b1, d, n, 1'b0);
      rand_item(d, n); step(1'b1, d, n, 1'b0);
      step(1'b0, 48'h0, 6'd0, 1'b0);
      tests++;
      if ({out_valid, err} !== 2'b11) begin fails++; $display("FAIL midrst_pre: got v=%b err=%b expected 1 1", out_valid, err); end
      reset = 1'b1;
      #1;
      tests++;
      if ({out_valid, mant, exp, zero, err, scan_out0} !== '0) begin
         fails++; $display("FAIL midrst_outputs: got v=%b m=%h e=%h z=%b err=%b expected all 0", out_valid, mant, exp, zero, err);
      end
      @(posedge clk); #1 reset = 1'b0;
      qd.delete(); qn.delete();
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
      step(1'b1, 48'h1, 6'd47, 1'b1);
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if (out_valid !== 1'b0) begin fails++; $display("FAIL midrst_lat: out_valid got %b expected 0", out_valid); end
      step(1'b0, 48'h0, 6'd0, 1'b1);
      tests++;
      if ({out_valid, mant, exp, zero, err} !== {1'b1, 48'h800000000000, 8'hD1, 1'b0, 1'b0}) begin
         fails++; $display("FAIL midrst_item: got v=%b m=%h e=%h z=%b err=%b expected 1 800000000000 d1 0 0", out_valid, mant, exp, zero, err);
      end
      $display("[TB] reset_midstream: m=%h e=%h", mant, exp);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_zero();
      test_backpressure();
      test_mismatch();
      test_random();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
